// File: rtl/amx_sym_tx_if.sv
// Byte-in / 6-bit-symbol-out handshake bundle for amx_sym_tx.
// master: the packer itself; slave: byte source plus symbol sink.
interface amx_sym_tx_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       flush;
  logic [5:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       busy;

  modport master (
    input  byte_in, byte_valid, flush, sym_ready,
    output byte_ready, sym_out, sym_valid, busy
  );

  modport slave (
    output byte_in, byte_valid, flush, sym_ready,
    input  byte_ready, sym_out, sym_valid, busy
  );
endinterface

// File: rtl/amx_sym_tx.sv
// AMX symbol-link transmitter: byte FIFO, 3-byte gather, MSB-first 4x6-bit symbol emit.
// Define AMX_TX_SYNC_EN to prefix every group with a SYNC_SYM frame header.
module amx_sym_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [5:0]  SYNC_SYM   = 6'h3F,
  parameter logic [5:0]  IDLE_SYM   = 6'h00
) (
  input logic          clk,
  input logic          rst,
  amx_sym_tx_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

`ifdef AMX_TX_SYNC_EN
  typedef enum logic [1:0] {StGather, StEmit, StSync} state_e;
`else
  typedef enum logic [1:0] {StGather, StEmit} state_e;
  logic [5:0] unused_sync;
  assign unused_sync = SYNC_SYM;
`endif

  logic [7:0] mem_q [FIFO_DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t       cnt_q, cnt_d;
  state_e     state_q, state_d;
  logic [23:0] g_q, g_d;
  logic [1:0] gcnt_q, gcnt_d;
  logic [1:0] idx_q, idx_d;
  logic       flush_pend_q, flush_pend_d;
  logic [5:0] sym_out_q, sym_out_d;
  logic       sym_valid_q, sym_valid_d;

  logic       full, empty, push, pop, grp_done, flush_clr;
  logic [7:0] rd_byte;

  assign full    = (cnt_q == cnt_t'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = bus.byte_valid & ~full;
  assign rd_byte = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    gcnt_d       = gcnt_q;
    idx_d        = idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    grp_done     = 1'b0;
    flush_clr    = 1'b0;
    flush_pend_d = flush_pend_q;
    sym_out_d    = IDLE_SYM;
    sym_valid_d  = 1'b0;

    unique case (state_q)
      StGather: begin
        if (!empty) begin
          pop = 1'b1;
          // First byte clears the low bytes so a flush pads with zeros for free.
          case (gcnt_q)
            2'd0:    g_d = {rd_byte, 16'h0000};
            2'd1:    g_d[15:8] = rd_byte;
            default: g_d[7:0] = rd_byte;
          endcase
          if (gcnt_q == 2'd2) grp_done = 1'b1;
          else                gcnt_d = gcnt_q + 2'd1;
        end else if (flush_pend_q) begin
          flush_clr = 1'b1;
          if (gcnt_q != 2'd0) grp_done = 1'b1;
        end
      end
      StEmit: begin
        if (bus.sym_ready) begin
          if (idx_q == 2'd3) state_d = StGather;
          else               idx_d = idx_q + 2'd1;
        end
      end
`ifdef AMX_TX_SYNC_EN
      StSync: begin
        if (bus.sym_ready) state_d = StEmit;
      end
`endif
      default: state_d = StGather;
    endcase

    if (grp_done) begin
      gcnt_d = 2'd0;
      idx_d  = 2'd0;
`ifdef AMX_TX_SYNC_EN
      state_d = StSync;
`else
      state_d = StEmit;
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    flush_pend_d = (flush_pend_q & ~flush_clr) | bus.flush;

    // Outputs are registered, so they are decoded from next-state values.
    sym_valid_d = (state_d != StGather);
    if (state_d == StEmit) begin
      unique case (idx_d)
        2'd0: sym_out_d = g_d[23:18];
        2'd1: sym_out_d = g_d[17:12];
        2'd2: sym_out_d = g_d[11:6];
        2'd3: sym_out_d = g_d[5:0];
      endcase
    end
`ifdef AMX_TX_SYNC_EN
    if (state_d == StSync) sym_out_d = SYNC_SYM;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= StGather;
      g_q          <= '0;
      gcnt_q       <= 2'd0;
      idx_q        <= 2'd0;
      flush_pend_q <= 1'b0;
      sym_out_q    <= IDLE_SYM;
      sym_valid_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= bus.byte_in;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      g_q          <= g_d;
      gcnt_q       <= gcnt_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      sym_out_q    <= sym_out_d;
      sym_valid_q  <= sym_valid_d;
    end
  end

  assign bus.byte_ready = ~full;
  assign bus.sym_out    = sym_out_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.busy       = ~empty | (gcnt_q != 2'd0) | (state_q != StGather) | flush_pend_q;

endmodule

// File: tb/tb_amx_sym_tx.sv
// Bench for amx_sym_tx: directed link scenarios plus randomized bytes/backpressure
// checked against a byte-group reference model.
module tb_amx_sym_tx;

  localparam logic [5:0] SyncSym = 6'h3F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amx_sym_tx_if bus ();

  amx_sym_tx #(
    .FIFO_DEPTH(4),
    .SYNC_SYM  (SyncSym),
    .IDLE_SYM  (6'h00)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [5:0]  exp_q[$];
  logic [7:0]  pend_b[$];
  logic        mon_en = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_out = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Four 6-bit symbols packed MSB-first in 24 bits, framed with SYNC when enabled.
  task automatic exp_syms(input logic [23:0] s);
`ifdef AMX_TX_SYNC_EN
    exp_q.push_back(SyncSym);
`endif
    for (int k = 0; k < 4; k++) exp_q.push_back(s[23-6*k -: 6]);
  endtask

  task automatic model_byte(input logic [7:0] b);
    pend_b.push_back(b);
    if (pend_b.size() == 3) begin
      exp_syms({pend_b[0], pend_b[1], pend_b[2]});
      pend_b.delete();
    end
  endtask

  task automatic model_flush();
    logic [7:0] b1;
    if (pend_b.size() != 0) begin
      b1 = (pend_b.size() > 1) ? pend_b[1] : 8'h00;
      exp_syms({pend_b[0], b1, 8'h00});
      pend_b.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit mdl);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!bus.byte_ready) check_eq("push_timeout", bus.byte_ready, 1);
    tick();
    bus.byte_valid = 1'b0;
    if (mdl) model_byte(b);
  endtask

  task automatic pulse_flush(input bit mdl);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    if (mdl) model_flush();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic find_sym(input logic [5:0] s);
    int n = 0;
    while (!(bus.sym_valid && bus.sym_out == s) && n < 40) begin
      tick();
      n++;
    end
    check_eq("find_sym", bus.sym_out, s);
  endtask

  // Scoreboard: every accepted symbol must be the next expected one; stalls must hold.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", bus.sym_valid, 1);
        check_eq("hold_data", bus.sym_out, prev_out);
      end
      if (bus.sym_valid && bus.sym_ready) begin
        if (exp_q.size() == 0) check_eq("extra_sym", exp_q.size(), 1);
        else                   check_eq("sym", bus.sym_out, exp_q.pop_front());
      end
      prev_stall = bus.sym_valid && !bus.sym_ready;
      prev_out   = bus.sym_out;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus.sym_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b7;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.sym_ready  = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_sym_valid", bus.sym_valid, 0);
    check_eq("rst_sym_out", bus.sym_out, 6'h00);
    check_eq("rst_byte_ready", bus.byte_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // AB,CD,EF at three consecutive edges; first symbol after the fourth edge
    exp_syms({6'h2A, 6'h3C, 6'h37, 6'h2F});
    push_byte(8'hAB, 0);
    push_byte(8'hCD, 0);
    push_byte(8'hEF, 0);
    check_eq("lat_pre", bus.sym_valid, 0);
    tick();
    check_eq("lat_post", bus.sym_valid, 1);
    wait_drain("t1_drain");
    tick();
    check_eq("t1_idle", bus.busy, 0);

    // Backpressure on symbol index 1 for five cycles
    exp_syms({6'h2A, 6'h3C, 6'h37, 6'h2F});
    push_byte(8'hAB, 0);
    push_byte(8'hCD, 0);
    push_byte(8'hEF, 0);
    find_sym(6'h3C);
    bus.sym_ready = 1'b0;
    repeat (5) begin
      tick();
      check_eq("t2_stall_valid", bus.sym_valid, 1);
      check_eq("t2_stall_sym", bus.sym_out, 6'h3C);
    end
    bus.sym_ready = 1'b1;
    wait_drain("t2_drain");

    // Eight bytes against a blocked sink: FIFO fills, eighth byte waits
    bus.sym_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_byte(8'($urandom), 1);
    check_eq("t3_full", bus.byte_ready, 0);
    check_eq("t3_busy", bus.busy, 1);
    b7 = 8'($urandom);
    bus.byte_in    = b7;
    bus.byte_valid = 1'b1;
    repeat (3) begin
      tick();
      check_eq("t3_refuse", bus.byte_ready, 0);
    end
    bus.sym_ready = 1'b1;
    push_byte(b7, 1);
    wait_drain("t3_groups");
    pulse_flush(1);
    wait_drain("t3_flush");
    tick();
    tick();
    check_eq("t3_idle", bus.busy, 0);

    // Single byte plus flush is zero-padded
    exp_syms({6'h3F, 6'h30, 6'h00, 6'h00});
    push_byte(8'hFF, 0);
    pulse_flush(0);
    wait_drain("t4_drain");
    tick();
    tick();
    check_eq("t4_idle", bus.busy, 0);

    // Reset mid-group discards everything
    exp_syms({6'h2A, 6'h3C, 6'h37, 6'h2F});
    push_byte(8'hAB, 0);
    push_byte(8'hCD, 0);
    push_byte(8'hEF, 0);
    find_sym(6'h3C);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick();
    check_eq("t5_sym_valid", bus.sym_valid, 0);
    check_eq("t5_sym_out", bus.sym_out, 6'h00);
    check_eq("t5_byte_ready", bus.byte_ready, 1);
    check_eq("t5_busy", bus.busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    exp_syms({6'h04, 6'h23, 6'h11, 6'h16});
    push_byte(8'h12, 0);
    push_byte(8'h34, 0);
    push_byte(8'h56, 0);
    wait_drain("t5_drain");

    // Random batches, random gaps and random sink backpressure
    rnd_rdy = 1'b1;
    repeat (25) begin
      int nb;
      nb = $urandom_range(1, 7);
      for (int i = 0; i < nb; i++) begin
        push_byte(8'($urandom), 1);
        if ($urandom_range(0, 2) == 0) tick();
      end
      wait_drain("rnd_groups");
      pulse_flush(1);
      wait_drain("rnd_flush");
      tick();
      tick();
      check_eq("rnd_idle", bus.busy, 0);
      check_eq("rnd_ready", bus.byte_ready, 1);
    end
    rnd_rdy = 1'b0;
    tick();
    bus.sym_ready = 1'b1;

    repeat (5) tick();
    check_eq("end_valid", bus.sym_valid, 0);
    check_eq("end_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
